// File: rtl/round_controller.sv
// rtl/round_controller.sv - game-round sequencer with key debounce and BCD scoring.
// Define ROUND_CTRL_HISCORE_EN to keep the high-score register and new_record flag.

module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_n,
    output logic press
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic          sync0;
    logic          sync1;
    logic          level;
    logic          level_q;
    logic [CW-1:0] cnt;

    // The counter only runs while the synced input disagrees with the accepted level,
    // so any bounce back to the accepted level restarts the stability window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync0   <= 1'b0;
            sync1   <= 1'b0;
            level   <= 1'b0;
            level_q <= 1'b0;
            press   <= 1'b0;
            cnt     <= '0;
        end else begin
            sync0   <= key_n;
            sync1   <= sync0;
            level_q <= level;
            press   <= level_q & ~level;
            if (sync1 == level) begin
                cnt <= '0;
            end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                level <= sync1;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

module round_controller #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int LOAD_CYCLES     = 2
) (
    input  logic       CLOCK_50,
    input  logic       resetn,
    input  logic       start_n,
    input  logic       hit_n,
    input  logic       timer_done,
    output logic       timer_run,
    output logic       timer_load_n,
    output logic [7:0] score,
    output logic [7:0] high_score,
    output logic       new_record,
    output logic [1:0] state
);
    localparam int LW = $clog2(LOAD_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        LOAD = 2'b01,
        RUN  = 2'b10,
        OVER = 2'b11
    } state_t;

    state_t        cur;
    state_t        nxt;
    logic          start_press;
    logic          hit_press;
    logic          done_s0;
    logic          done_s1;
    logic          done_armed;
    logic [LW-1:0] load_cnt;
    logic [7:0]    score_inc;

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_start_key (
        .clk   (CLOCK_50),
        .rst_n (resetn),
        .key_n (start_n),
        .press (start_press)
    );

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_hit_key (
        .clk   (CLOCK_50),
        .rst_n (resetn),
        .key_n (hit_n),
        .press (hit_press)
    );

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            cur <= IDLE;
        end else begin
            cur <= nxt;
        end
    end

    always_comb begin
        nxt = cur;
        case (cur)
            IDLE: if (start_press) nxt = LOAD;
            LOAD: if (load_cnt == LW'(LOAD_CYCLES - 1)) nxt = RUN;
            RUN:  if (done_s1 && done_armed) nxt = OVER;
            OVER: if (start_press) nxt = LOAD;
            default: nxt = IDLE;
        endcase
    end

    always_comb begin
        timer_run    = (cur != IDLE);
        timer_load_n = (cur != LOAD);
    end

    assign state = cur;

    // Saturating BCD increment of the current score.
    always_comb begin
        score_inc = score;
        if (score != 8'h99) begin
            if (score[3:0] == 4'd9) begin
                score_inc = {score[7:4] + 4'd1, 4'd0};
            end else begin
                score_inc = {score[7:4], score[3:0] + 4'd1};
            end
        end
    end

    // done_armed keeps a done level left over from the previous round from ending this one.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            done_s0    <= 1'b0;
            done_s1    <= 1'b0;
            done_armed <= 1'b0;
            load_cnt   <= '0;
            score      <= 8'h00;
        end else begin
            done_s0 <= timer_done;
            done_s1 <= done_s0;
            if (cur == LOAD && nxt == RUN) begin
                done_armed <= 1'b0;
            end else if (cur == RUN && !done_s1) begin
                done_armed <= 1'b1;
            end
            if (cur == LOAD) begin
                load_cnt <= load_cnt + 1'b1;
            end else begin
                load_cnt <= '0;
            end
            if (cur == LOAD) begin
                score <= 8'h00;
            end else if (cur == RUN && hit_press) begin
                score <= score_inc;
            end
        end
    end

`ifdef ROUND_CTRL_HISCORE_EN
    logic [7:0] score_final;

    // A hit landing on the same edge as the round end is part of the final score.
    assign score_final = (cur == RUN && hit_press) ? score_inc : score;

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            high_score <= 8'h00;
            new_record <= 1'b0;
        end else begin
            if (cur == RUN && nxt == OVER && score_final > high_score) begin
                high_score <= score_final;
                new_record <= 1'b1;
            end else if (cur == OVER && nxt == LOAD) begin
                new_record <= 1'b0;
            end
        end
    end
`else
    assign high_score = 8'h00;
    assign new_record = 1'b0;
`endif

endmodule

// File: tb/tb_round_controller.sv
// tb/tb_round_controller.sv - randomized self-checking bench for round_controller.

module tb_round_controller;
    localparam int DB = 4;
    localparam int LC = 2;
`ifdef ROUND_CTRL_HISCORE_EN
    localparam bit HS_EN = 1'b1;
`else
    localparam bit HS_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       start_n = 1'b1;
    logic       hit_n = 1'b1;
    logic       timer_done = 1'b0;
    logic       timer_run;
    logic       timer_load_n;
    logic [7:0] score;
    logic [7:0] high_score;
    logic       new_record;
    logic [1:0] state;

    int total = 0;
    int bad = 0;
    int hits = 0;
    int hs_model = 0;

    round_controller #(.DEBOUNCE_CYCLES(DB), .LOAD_CYCLES(LC)) dut (
        .CLOCK_50     (clk),
        .resetn       (resetn),
        .start_n      (start_n),
        .hit_n        (hit_n),
        .timer_done   (timer_done),
        .timer_run    (timer_run),
        .timer_load_n (timer_load_n),
        .score        (score),
        .high_score   (high_score),
        .new_record   (new_record),
        .state        (state)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] bcd(input int n);
        int m;
        m = (n > 99) ? 99 : n;
        return {4'(m / 10), 4'(m % 10)};
    endfunction

    function automatic logic [7:0] exp_high();
        return HS_EN ? bcd(hs_model) : 8'h00;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_hit();
        int lo;
        int hi;
        lo = $urandom_range(6, 10);
        hi = $urandom_range(6, 10);
        hit_n = 1'b0;
        tick(lo);
        hit_n = 1'b1;
        tick(hi);
    endtask

    task automatic press_start(output int entries, output int low_cycles, output logic [1:0] final_st);
        logic [1:0] prev;
        entries = 0;
        low_cycles = 0;
        prev = state;
        start_n = 1'b0;
        for (int i = 0; i < 26; i++) begin
            if (i == 10) start_n = 1'b1;
            @(negedge clk);
            if (state == 2'b01 && prev != 2'b01) entries++;
            if (!timer_load_n) low_cycles++;
            prev = state;
        end
        final_st = state;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        tick(3);
        total++; if (state !== 2'b00) begin bad++; $display("FAIL reset_state got=%b exp=00", state); end
        total++; if (score !== 8'h00) begin bad++; $display("FAIL reset_score got=%h exp=00", score); end
        total++; if (timer_run !== 1'b0) begin bad++; $display("FAIL reset_run got=%b exp=0", timer_run); end
        total++; if (timer_load_n !== 1'b1) begin bad++; $display("FAIL reset_load_n got=%b exp=1", timer_load_n); end
        total++; if (high_score !== 8'h00) begin bad++; $display("FAIL reset_high got=%h exp=00", high_score); end
        total++; if (new_record !== 1'b0) begin bad++; $display("FAIL reset_new_record got=%b exp=0", new_record); end
        resetn = 1'b1;
        tick(12);
    endtask

    task automatic test_start();
        int e;
        int l;
        logic [1:0] f;
        press_start(e, l, f);
        hits = 0;
        total++; if (e != 1) begin bad++; $display("FAIL start_load_entries got=%0d exp=1", e); end
        total++; if (l != LC) begin bad++; $display("FAIL start_load_low_cycles got=%0d exp=%0d", l, LC); end
        total++; if (f !== 2'b10) begin bad++; $display("FAIL start_final_state got=%b exp=10", f); end
        total++; if (score !== 8'h00) begin bad++; $display("FAIL start_score got=%h exp=00", score); end
        total++; if (timer_run !== 1'b1) begin bad++; $display("FAIL start_run got=%b exp=1", timer_run); end
    endtask

    task automatic test_bounce();
        int c;
        int d;
        c = 0;
        while (c < 20) begin
            hit_n = ~hit_n;
            d = $urandom_range(1, 2);
            tick(d);
            c += d;
        end
        hit_n = 1'b0;
        tick(10);
        hit_n = 1'b1;
        tick(10);
        hits++;
        total++; if (score !== bcd(hits)) begin bad++; $display("FAIL bounce_score got=%h exp=%h", score, bcd(hits)); end
    endtask

    task automatic test_hits();
        int extra;
        while (hits < 12) begin
            do_hit();
            hits++;
        end
        total++; if (score !== 8'h12) begin bad++; $display("FAIL hits12_score got=%h exp=12", score); end
        extra = 88 + $urandom_range(1, 5);
        for (int i = 0; i < extra; i++) begin
            do_hit();
            hits++;
            if (hits % 10 == 0) begin
                total++; if (score !== bcd(hits)) begin bad++; $display("FAIL hits_progress n=%0d got=%h exp=%h", hits, score, bcd(hits)); end
            end
        end
        total++; if (score !== 8'h99) begin bad++; $display("FAIL hits_saturate got=%h exp=99", score); end
    endtask

    task automatic test_start_in_run();
        int e;
        int l;
        logic [1:0] f;
        press_start(e, l, f);
        total++; if (e != 0) begin bad++; $display("FAIL run_start_entries got=%0d exp=0", e); end
        total++; if (f !== 2'b10) begin bad++; $display("FAIL run_start_state got=%b exp=10", f); end
        total++; if (score !== bcd(hits)) begin bad++; $display("FAIL run_start_score got=%h exp=%h", score, bcd(hits)); end
    endtask

    task automatic test_record_round();
        int e;
        int l;
        logic [1:0] f;
        int cyc;
        resetn = 1'b0;
        tick(2);
        resetn = 1'b1;
        hs_model = 0;
        timer_done = 1'b0;
        tick(12);
        press_start(e, l, f);
        hits = 0;
        for (int i = 0; i < 7; i++) begin
            do_hit();
            hits++;
        end
        timer_done = 1'b1;
        cyc = 0;
        for (int i = 1; i <= 8 && cyc == 0; i++) begin
            tick(1);
            if (state == 2'b11) cyc = i;
        end
        if (hits > hs_model) hs_model = hits;
        total++; if (cyc < 1 || cyc > 3) begin bad++; $display("FAIL over_latency got=%0d exp=1..3", cyc); end
        total++; if (score !== 8'h07) begin bad++; $display("FAIL over_score got=%h exp=07", score); end
        total++; if (high_score !== exp_high()) begin bad++; $display("FAIL over_high got=%h exp=%h", high_score, exp_high()); end
        total++; if (new_record !== HS_EN) begin bad++; $display("FAIL over_new_record got=%b exp=%b", new_record, HS_EN); end
        total++; if (timer_run !== 1'b1 || timer_load_n !== 1'b1) begin bad++; $display("FAIL over_timer got=%b%b exp=11", timer_run, timer_load_n); end
        do_hit();
        total++; if (score !== 8'h07) begin bad++; $display("FAIL over_hit_ignored got=%h exp=07", score); end
    endtask

    task automatic test_second_round();
        int e;
        int l;
        logic [1:0] f;
        int seen;
        timer_done = 1'b0;
        press_start(e, l, f);
        hits = 0;
        total++; if (f !== 2'b10) begin bad++; $display("FAIL r2_state got=%b exp=10", f); end
        total++; if (new_record !== 1'b0) begin bad++; $display("FAIL r2_new_record_cleared got=%b exp=0", new_record); end
        for (int i = 0; i < 4; i++) begin
            do_hit();
            hits++;
        end
        hit_n = 1'b0;
        tick(5);
        timer_done = 1'b1;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            tick(1);
            if (state == 2'b11) seen = 1;
        end
        hits++;
        hit_n = 1'b1;
        tick(10);
        if (hits > hs_model) hs_model = hits;
        total++; if (seen != 1) begin bad++; $display("FAIL r2_over_reached got=%0d exp=1", seen); end
        total++; if (score !== 8'h05) begin bad++; $display("FAIL r2_score got=%h exp=05", score); end
        total++; if (high_score !== exp_high()) begin bad++; $display("FAIL r2_high got=%h exp=%h", high_score, exp_high()); end
        total++; if (new_record !== 1'b0) begin bad++; $display("FAIL r2_new_record got=%b exp=0", new_record); end
    endtask

    task automatic test_done_stuck_reset();
        int e;
        int l;
        logic [1:0] f;
        int left_run;
        press_start(e, l, f);
        hits = 0;
        total++; if (f !== 2'b10) begin bad++; $display("FAIL stuck_enter_run got=%b exp=10", f); end
        left_run = 0;
        for (int i = 0; i < 2; i++) begin
            do_hit();
            hits++;
            if (state != 2'b10) left_run++;
        end
        for (int i = 0; i < 20; i++) begin
            tick(1);
            if (state != 2'b10) left_run++;
        end
        total++; if (left_run != 0) begin bad++; $display("FAIL stuck_left_run got=%0d exp=0", left_run); end
        total++; if (score !== bcd(hits)) begin bad++; $display("FAIL stuck_score got=%h exp=%h", score, bcd(hits)); end
        timer_done = 1'b0;
        tick(4);
        total++; if (state !== 2'b10) begin bad++; $display("FAIL stuck_after_drop got=%b exp=10", state); end
        @(posedge clk);
        #2 resetn = 1'b0;
        #1;
        total++; if (state !== 2'b00) begin bad++; $display("FAIL async_reset_state got=%b exp=00", state); end
        total++; if (score !== 8'h00) begin bad++; $display("FAIL async_reset_score got=%h exp=00", score); end
        total++; if (high_score !== 8'h00) begin bad++; $display("FAIL async_reset_high got=%h exp=00", high_score); end
        total++; if (timer_run !== 1'b0 || timer_load_n !== 1'b1) begin bad++; $display("FAIL async_reset_timer got=%b%b exp=01", timer_run, timer_load_n); end
        tick(2);
        resetn = 1'b1;
        tick(5);
    endtask

    initial begin
        test_reset();
        test_start();
        test_bounce();
        test_hits();
        test_start_in_run();
        test_record_round();
        test_second_round();
        test_done_stuck_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
